// File: rtl/jstk_move_if.sv
// Move-command bus between the joystick front end and the 2048 board-update logic.
interface jstk_move_if;
  logic [2:0]  dir;
  logic        move_ready;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        armed;
  logic [15:0] move_count;

  modport master (
    output dir, move_ready,
    input  move_valid, move_dir, armed, move_count
  );

  modport slave (
    input  dir, move_ready,
    output move_valid, move_dir, armed, move_count
  );
endinterface

// File: rtl/jstk_move_gen.sv
// Debounced joystick-to-move generator: one move per deflection, re-armed by centre.
// Optional auto-repeat while a deflection is held: define JSTK_AUTO_REPEAT_EN.
module jstk_move_gen #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  jstk_move_if.slave  bus
);
  localparam int unsigned DIR_W   = 3;
  localparam int unsigned MOVE_W  = 2;
  localparam int unsigned COUNT_W = 16;
  localparam logic [DIR_W-1:0] CODE_CENTRE = DIR_W'(4);
  localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {WAIT_CENTER, IDLE, ISSUE, RELEASE} state_e;

  if (STABLE_CYCLES == 0 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W) ||
      64'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("jstk_move_gen: STABLE_CYCLES/REPEAT_CYCLES do not fit CNT_W");
  end

  state_e              state_q, state_d;
  logic [DIR_W-1:0]    dir_q, dir_d, dir_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                move_valid_q, move_valid_d;
  logic [MOVE_W-1:0]   move_dir_q, move_dir_d;
  logic                armed_q, armed_d;
  logic [COUNT_W-1:0]  move_count_q, move_count_d;
  logic                stable_c;
  logic                handshake_c;
  logic                rep_hit_c;

  // Input stage and stability counter; stable needs the code unchanged for a full window
  always_comb begin
    dir_d = (bus.dir > CODE_CENTRE) ? CODE_CENTRE : bus.dir;
    cnt_d = cnt_q;
    if (dir_q != dir_prev_q)     cnt_d = '0;
    else if (cnt_q < STABLE_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  assign stable_c    = (cnt_q == STABLE_MAX) && (dir_q == dir_prev_q);
  assign handshake_c = move_valid_q && bus.move_ready;

`ifdef JSTK_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;

  // Repeat timer runs only while the last issued move stays stably held in RELEASE
  always_comb begin
    rep_d     = '0;
    rep_hit_c = 1'b0;
    if (state_q == RELEASE && stable_c && dir_q == {1'b0, move_dir_q}) begin
      if (rep_q >= REPEAT_LAST) rep_hit_c = 1'b1;
      else                      rep_d     = rep_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_hit_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_CENTER;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_CENTER: if (stable_c && dir_q == CODE_CENTRE) state_d = IDLE;
      IDLE:        if (stable_c && dir_q != CODE_CENTRE) state_d = ISSUE;
      ISSUE:       if (handshake_c)                      state_d = RELEASE;
      RELEASE: begin
        if (stable_c && dir_q == CODE_CENTRE) state_d = IDLE;
        else if (rep_hit_c)                   state_d = ISSUE;
      end
      default:                                           state_d = WAIT_CENTER;
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the FSM
  always_comb begin
    move_valid_d = (state_d == ISSUE);
    armed_d      = (state_d == IDLE);
    move_dir_d   = move_dir_q;
    move_count_d = move_count_q;
    if (state_q == IDLE && state_d == ISSUE) move_dir_d   = dir_q[MOVE_W-1:0];
    if (handshake_c)                         move_count_d = move_count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= CODE_CENTRE;
      dir_prev_q   <= CODE_CENTRE;
      cnt_q        <= '0;
      move_valid_q <= 1'b0;
      move_dir_q   <= '0;
      armed_q      <= 1'b0;
      move_count_q <= '0;
    end else begin
      dir_q        <= dir_d;
      dir_prev_q   <= dir_q;
      cnt_q        <= cnt_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      armed_q      <= armed_d;
      move_count_q <= move_count_d;
    end
  end

  assign bus.move_valid = move_valid_q;
  assign bus.move_dir   = move_dir_q;
  assign bus.armed      = armed_q;
  assign bus.move_count = move_count_q;
endmodule
